frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
- Top-level game control FSM; the initiator side of the per-frame state/draw handshake that sprite blocks (link, enemies) respond to.
- Generates the one-hot phase strobes init, idle, gen_move, apply_move and the per-client draw requests; consumes each client's draw_done.
- Sits between the frame-rate timer domain and all sprite modules; paces one game update per frame tick.

Parameters:
- FRAME_CYCLES, 833333, clock cycles per frame tick (50 MHz / 60 Hz); counter width is 20 bits, legal range 8..2^20-1.
- INIT_CYCLES, 4, cycles init is held high after reset release; range 1..255.
- DRAW_TIMEOUT, 65535, maximum cycles a draw request waits for its draw_done before it is abandoned; 16-bit counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- link_draw_done  in  1  link sprite finished drawing; level held high while its draw request stays high.
- enemies_draw_done  in  1  enemy group finished drawing; level held high while its draw request stays high.
- pause  in  1  hold in IDLE; present only with PAUSE_EN.
- init  out  1  initialise all sprites.
- idle  out  1  waiting for the frame tick.
- gen_move  out  1  sprites compute their next move.
- apply_move  out  1  sprites commit the move and resolve collisions.
- draw_link  out  1  draw request to the link sprite.
- draw_enemies  out  1  draw request to the enemy group.
- frame_count  out  16  number of completed frames; wraps from 65535 to 0.
- frame_overrun  out  1  sticky flag: a frame tick was missed.
- draw_timeout  out  1  sticky flag: a draw phase was abandoned.

Behaviour:
- Reset (async assert): state goes to INIT and the INIT counter clears. All outputs are 0 except init, which is 1. The frame counter, tick_pending, frame_count, frame_overrun and draw_timeout all reset to 0.
- Phase outputs are registered and decoded from the state register. At most one of init/idle/gen_move/apply_move/draw_link/draw_enemies is high in any cycle.
- States and transitions:
  - INIT: init=1 for exactly INIT_CYCLES cycles after reset deasserts, then go to IDLE.
  - IDLE: idle=1. Go to GEN when tick_pending=1, or when frame_tick occurs in the same cycle. tick_pending clears on that exit.
  - GEN: gen_move=1 for exactly 1 cycle, then go to APPLY.
  - APPLY: apply_move=1 for exactly 1 cycle, then go to DRAW_L.
  - DRAW_L: draw_link=1 until link_draw_done is sampled 1, then go to DRAW_E. draw_link drops the cycle after done is sampled.
  - DRAW_E: draw_enemies=1 until enemies_draw_done is sampled 1, then go to IDLE. frame_count increments on this exit.
- Draw-done handling: done is sampled only while in the matching draw state. A done already high on the first cycle of a draw state is accepted (1-cycle draw phase).
- Draw timeout: a 16-bit wait counter clears on entry to each draw state. If it reaches DRAW_TIMEOUT without done, the FSM advances exactly as if done had arrived, and draw_timeout is set. frame_count still increments on a DRAW_E exit by timeout.
- Frame timer: free-running 0..FRAME_CYCLES-1, starting at reset release. frame_tick pulses for 1 cycle on the wrap.
  - A tick seen outside IDLE sets tick_pending.
  - A tick seen while tick_pending is already 1 sets frame_overrun. Extra ticks are not queued; at most one tick is pending.
- Sticky flags (frame_overrun, draw_timeout) clear only on reset.
- Reset mid-draw: outputs drop asynchronously and the next frame restarts from INIT.

Optional Feature:
- Macro: FRAME_SEQUENCER_PAUSE_EN.
- Defined: the pause port exists.
  - While pause=1 in IDLE, the FSM stays in IDLE even if a tick is pending.
  - Ticks during pause keep updating tick_pending but never set frame_overrun.
  - pause does not interrupt GEN, APPLY or the draw states.
- Undefined: no pause port; IDLE behaves as described above.

Test Plan:
- Bench parameters: FRAME_CYCLES=32, INIT_CYCLES=4, DRAW_TIMEOUT=16.
- Reset release -> init=1 for cycles 0-3 and idle=1 at cycle 4; all flags 0.
- First tick at cycle 31, both done inputs returned 2 cycles after their request -> gen_move=1 at cycle 32, apply_move=1 at cycle 33, draw_link at 34-36, draw_enemies at 37-39, idle at 40, frame_count=1.
- link_draw_done held 0 -> draw_link drops after 16 cycles, draw_timeout=1, draw_enemies follows.
- enemies_draw_done withheld across 2 tick wraps -> frame_overrun=1; after done, exactly one extra frame runs back-to-back from IDLE.
- Reset asserted during DRAW_E -> all outputs 0 except init=1 in the same cycle (async); flags cleared; restart from INIT.
- PAUSE_EN defined, pause=1 across 3 ticks -> idle stays 1 with no overrun. On pause=0, gen_move asserts the next cycle; frame_count advances by 1 per frame.

Source files
------------

// File: rtl/frame_sequencer_if.sv
// Frame sequencer handshake bundle: phase strobes, draw requests/dones, status.
// Optional pause input exists only when FRAME_SEQUENCER_PAUSE_EN is defined.
interface frame_sequencer_if;
    logic        link_draw_done;
    logic        enemies_draw_done;
`ifdef FRAME_SEQUENCER_PAUSE_EN
    logic        pause;
`endif
    logic        init;
    logic        idle;
    logic        gen_move;
    logic        apply_move;
    logic        draw_link;
    logic        draw_enemies;
    logic [15:0] frame_count;
    logic        frame_overrun;
    logic        draw_timeout;

    modport master (
`ifdef FRAME_SEQUENCER_PAUSE_EN
        input  pause,
`endif
        input  link_draw_done,
        input  enemies_draw_done,
        output init,
        output idle,
        output gen_move,
        output apply_move,
        output draw_link,
        output draw_enemies,
        output frame_count,
        output frame_overrun,
        output draw_timeout
    );

    modport slave (
`ifdef FRAME_SEQUENCER_PAUSE_EN
        output pause,
`endif
        output link_draw_done,
        output enemies_draw_done,
        input  init,
        input  idle,
        input  gen_move,
        input  apply_move,
        input  draw_link,
        input  draw_enemies,
        input  frame_count,
        input  frame_overrun,
        input  draw_timeout
    );
endinterface

// File: rtl/frame_sequencer.sv
// Per-frame game control FSM: init, idle, gen/apply move, link and enemy draws.
// Define FRAME_SEQUENCER_PAUSE_EN to add the pause input that holds the FSM in IDLE.
module frame_sequencer #(
    parameter int FRAME_CYCLES = 833333,
    parameter int INIT_CYCLES  = 4,
    parameter int DRAW_TIMEOUT = 65535
) (
    input logic               clock,
    input logic               reset,
    frame_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_GEN,
        S_APPLY,
        S_DRAW_L,
        S_DRAW_E
    } state_t;

    localparam logic [19:0] FRAME_LAST = 20'(FRAME_CYCLES - 1);
    localparam logic [7:0]  INIT_LAST  = 8'(INIT_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST  = 16'(DRAW_TIMEOUT - 1);

    state_t      state;
    state_t      nxt;
    logic [19:0] frame_cnt;
    logic [7:0]  init_cnt;
    logic [15:0] wait_cnt;
    logic        tick_pending;
    logic        frame_tick;
    logic        paused;
    logic        wait_hit;
    logic        leave_idle;

`ifdef FRAME_SEQUENCER_PAUSE_EN
    assign paused = bus.pause;
`else
    assign paused = 1'b0;
`endif

    assign frame_tick = (frame_cnt == FRAME_LAST);
    assign wait_hit   = (wait_cnt == WAIT_LAST);
    assign leave_idle = (state == S_IDLE) && (nxt == S_GEN);

    // Next-state decode; a draw phase ends on its done or on the wait limit.
    always_comb begin
        nxt = state;
        unique case (state)
            S_INIT:   if (init_cnt == INIT_LAST) nxt = S_IDLE;
            S_IDLE:   if (!paused && (tick_pending || frame_tick)) nxt = S_GEN;
            S_GEN:    nxt = S_APPLY;
            S_APPLY:  nxt = S_DRAW_L;
            S_DRAW_L: if (bus.link_draw_done || wait_hit) nxt = S_DRAW_E;
            S_DRAW_E: if (bus.enemies_draw_done || wait_hit) nxt = S_IDLE;
            default:  nxt = S_INIT;
        endcase
    end

    // Free-running frame timer; frame_tick marks the wrap cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) frame_cnt <= '0;
        else if (frame_tick) frame_cnt <= '0;
        else frame_cnt <= frame_cnt + 20'd1;
    end

    // One-deep tick buffer; a second tick while one is waiting is an overrun.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_pending      <= 1'b0;
            bus.frame_overrun <= 1'b0;
        end else begin
            if (leave_idle) tick_pending <= 1'b0;
            else if (frame_tick) tick_pending <= 1'b1;
            if (frame_tick && tick_pending && !paused)
                bus.frame_overrun <= 1'b1;
        end
    end

    // State register, phase counters, status and registered phase strobes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= S_INIT;
            init_cnt         <= '0;
            wait_cnt         <= '0;
            bus.frame_count  <= '0;
            bus.draw_timeout <= 1'b0;
            bus.init         <= 1'b1;
            bus.idle         <= 1'b0;
            bus.gen_move     <= 1'b0;
            bus.apply_move   <= 1'b0;
            bus.draw_link    <= 1'b0;
            bus.draw_enemies <= 1'b0;
        end else begin
            state <= nxt;
            if (state == S_INIT) init_cnt <= init_cnt + 8'd1;
            if (nxt != state) wait_cnt <= '0;
            else if (state == S_DRAW_L || state == S_DRAW_E)
                wait_cnt <= wait_cnt + 16'd1;
            if (wait_hit &&
                ((state == S_DRAW_L && !bus.link_draw_done) ||
                 (state == S_DRAW_E && !bus.enemies_draw_done)))
                bus.draw_timeout <= 1'b1;
            if (state == S_DRAW_E && nxt == S_IDLE)
                bus.frame_count <= bus.frame_count + 16'd1;
            bus.init         <= (nxt == S_INIT);
            bus.idle         <= (nxt == S_IDLE);
            bus.gen_move     <= (nxt == S_GEN);
            bus.apply_move   <= (nxt == S_APPLY);
            bus.draw_link    <= (nxt == S_DRAW_L);
            bus.draw_enemies <= (nxt == S_DRAW_E);
        end
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: phase-change events checked in order.
// Pause scenario runs only when FRAME_SEQUENCER_PAUSE_EN is defined.
module tb_frame_sequencer;
    localparam int FC = 32;
    localparam int IC = 4;
    localparam int DT = 16;

    localparam logic [5:0] P_INIT  = 6'b000001;
    localparam logic [5:0] P_IDLE  = 6'b000010;
    localparam logic [5:0] P_GEN   = 6'b000100;
    localparam logic [5:0] P_APPLY = 6'b001000;
    localparam logic [5:0] P_DL    = 6'b010000;
    localparam logic [5:0] P_DE    = 6'b100000;

    typedef struct {
        int         cyc;
        logic [5:0] ph;
        int         fc;
        logic       ov;
        logic       to;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc;
    int   checks = 0;
    int   passed = 0;
    int   link_lat = 2;
    int   en_lat = 2;
    ev_t  exp_q[$];

    frame_sequencer_if bus();

    frame_sequencer #(
        .FRAME_CYCLES(FC),
        .INIT_CYCLES (IC),
        .DRAW_TIMEOUT(DT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    function automatic logic [5:0] phase();
        return {bus.draw_enemies, bus.draw_link, bus.apply_move,
                bus.gen_move, bus.idle, bus.init};
    endfunction

    task automatic push(input int c, input logic [5:0] ph, input int fc,
                        input logic ov, input logic to);
        ev_t e;
        e.cyc = c;
        e.ph  = ph;
        e.fc  = fc;
        e.ov  = ov;
        e.to  = to;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        do begin
            @(posedge clock);
            #1;
        end while (cyc < n);
    endtask

    // Sprite-side responder: done rises lat cycles after the request and
    // stays high while the request is held; lat < 0 withholds done.
    initial begin
        int lcnt;
        int ecnt;
        lcnt = 0;
        ecnt = 0;
        bus.link_draw_done = 1'b0;
        bus.enemies_draw_done = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            lcnt = bus.draw_link ? lcnt + 1 : 0;
            ecnt = bus.draw_enemies ? ecnt + 1 : 0;
            bus.link_draw_done = (link_lat >= 0) && bus.draw_link &&
                                 (lcnt - 1 >= link_lat);
            bus.enemies_draw_done = (en_lat >= 0) && bus.draw_enemies &&
                                    (ecnt - 1 >= en_lat);
        end
    end

    // Monitor: every change of the phase strobes pops one expected event.
    initial begin
        logic [5:0] prev;
        logic [5:0] cur;
        ev_t        e;
        prev = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev = '0;
            end else begin
                cur = phase();
                if (cur != prev) begin
                    prev = cur;
                    checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_phase cyc=%0d got ph=%b fc=%0d, want no event",
                                 cyc, cur, bus.frame_count);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc == cyc && e.ph == cur &&
                            e.fc == int'(bus.frame_count) &&
                            e.ov == bus.frame_overrun &&
                            e.to == bus.draw_timeout)
                            passed++;
                        else
                            $display("FAIL phase_event got cyc=%0d ph=%b fc=%0d ov=%b to=%b, want cyc=%0d ph=%b fc=%0d ov=%b to=%b",
                                     cyc, cur, bus.frame_count, bus.frame_overrun,
                                     bus.draw_timeout, e.cyc, e.ph, e.fc, e.ov, e.to);
                    end
                end
            end
        end
    end

    initial begin
        int s;
        logic [5:0] ph;
`ifdef FRAME_SEQUENCER_PAUSE_EN
        bus.pause = 1'b0;
`endif
        // Normal frames, then a link draw timeout on the third frame.
        link_lat = 2;
        en_lat = 2;
        push(0,   P_INIT,  0, 0, 0);
        push(4,   P_IDLE,  0, 0, 0);
        push(32,  P_GEN,   0, 0, 0);
        push(33,  P_APPLY, 0, 0, 0);
        push(34,  P_DL,    0, 0, 0);
        push(37,  P_DE,    0, 0, 0);
        push(40,  P_IDLE,  1, 0, 0);
        push(64,  P_GEN,   1, 0, 0);
        push(65,  P_APPLY, 1, 0, 0);
        push(66,  P_DL,    1, 0, 0);
        push(69,  P_DE,    1, 0, 0);
        push(72,  P_IDLE,  2, 0, 0);
        push(96,  P_GEN,   2, 0, 0);
        push(97,  P_APPLY, 2, 0, 0);
        push(98,  P_DL,    2, 0, 0);
        push(114, P_DE,    2, 0, 1);
        push(117, P_IDLE,  3, 0, 1);
        do_reset();
        wait_cyc(80);
        link_lat = -1;
        wait_cyc(120);

        // All dones withheld: 35-cycle frames drift against the 32-cycle
        // tick until frame 10 spans two ticks and flags an overrun.
        link_lat = -1;
        en_lat = -1;
        push(0, P_INIT, 0, 0, 0);
        push(4, P_IDLE, 0, 0, 0);
        for (int i = 0; i <= 10; i++) begin
            s = 31 + 35 * i;
            push(s + 1,  P_GEN,   i,     0,       i > 0);
            push(s + 2,  P_APPLY, i,     0,       i > 0);
            push(s + 3,  P_DL,    i,     0,       i > 0);
            push(s + 19, P_DE,    i,     0,       1);
            push(s + 35, P_IDLE,  i + 1, i == 10, 1);
        end
        push(417, P_GEN,   11, 1, 1);
        push(418, P_APPLY, 11, 1, 1);
        push(419, P_DL,    11, 1, 1);
        push(422, P_DE,    11, 1, 1);
        push(425, P_IDLE,  12, 1, 1);
        push(448, P_GEN,   12, 1, 1);
        push(449, P_APPLY, 12, 1, 1);
        push(450, P_DL,    12, 1, 1);
        push(453, P_DE,    12, 1, 1);
        do_reset();
        wait_cyc(417);
        link_lat = 2;
        en_lat = 2;

        // Asynchronous reset in the middle of the enemy draw.
        wait_cyc(454);
        #1 reset = 1'b1;
        #1;
        ph = phase();
        checks++;
        if (ph == P_INIT && bus.frame_count == 16'd0 &&
            !bus.frame_overrun && !bus.draw_timeout)
            passed++;
        else
            $display("FAIL async_reset got ph=%b fc=%0d ov=%b to=%b, want ph=%b fc=0 ov=0 to=0",
                     ph, bus.frame_count, bus.frame_overrun, bus.draw_timeout, P_INIT);
        push(0,  P_INIT,  0, 0, 0);
        push(4,  P_IDLE,  0, 0, 0);
        push(32, P_GEN,   0, 0, 0);
        push(33, P_APPLY, 0, 0, 0);
        push(34, P_DL,    0, 0, 0);
        push(37, P_DE,    0, 0, 0);
        push(40, P_IDLE,  1, 0, 0);
        do_reset();
        wait_cyc(45);

`ifdef FRAME_SEQUENCER_PAUSE_EN
        // Pause across three ticks, then release: frame starts next cycle.
        bus.pause = 1'b1;
        push(0,   P_INIT,  0, 0, 0);
        push(4,   P_IDLE,  0, 0, 0);
        push(101, P_GEN,   0, 0, 0);
        push(102, P_APPLY, 0, 0, 0);
        push(103, P_DL,    0, 0, 0);
        push(106, P_DE,    0, 0, 0);
        push(109, P_IDLE,  1, 0, 0);
        push(128, P_GEN,   1, 0, 0);
        push(129, P_APPLY, 1, 0, 0);
        push(130, P_DL,    1, 0, 0);
        push(133, P_DE,    1, 0, 0);
        push(136, P_IDLE,  2, 0, 0);
        do_reset();
        wait_cyc(100);
        bus.pause = 1'b0;
        wait_cyc(140);
`endif

        checks++;
        if (exp_q.size() == 0)
            passed++;
        else
            $display("FAIL leftover_events got %0d pending, want 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
